// File: rtl/fp_add_align.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_align
// Purpose  : Pre-add alignment stage for a binary32 adder. Orders the operands
//            by magnitude and right-shifts the smaller significand one bit per
//            cycle, folding the shifted-out bits into a sticky bit.
// Revision : 1.0 - initial release
// ============================================================================
module fp_add_align #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int SIG_W = MAN_W + 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W-1:0]       out_exp,
    output logic                   out_sign_l,
    output logic                   out_sign_s,
    output logic [SIG_W-1:0]       out_man_l,
    output logic [SIG_W-1:0]       out_man_s,
    output logic                   out_sub,
    output logic                   out_swap,
    output logic                   out_special
);

    localparam int OP_W  = EXP_W + MAN_W + 1;
    localparam int CNT_W = $clog2(SIG_W + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(SIG_W);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [EXP_W-1:0] C_EXP_ONE = EXP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [EXP_W-1:0] w_exp_a_raw, w_exp_b_raw;
    logic [EXP_W-1:0] w_exp_a, w_exp_b;
    logic [MAN_W:0]   w_sig_a, w_sig_b;
    logic             w_swap;
    logic [EXP_W-1:0] w_exp_l, w_exp_s;
    logic [MAN_W:0]   w_sig_l, w_sig_s;
    logic             w_sign_l, w_sign_s;
    logic [EXP_W-1:0] w_diff;
    logic [CNT_W-1:0] w_cnt_init;
    logic             w_special;

    logic [CNT_W-1:0] r_cnt;
    logic [EXP_W-1:0] r_exp;
    logic             r_sign_l, r_sign_s, r_sub, r_swap, r_special;
    logic [SIG_W-1:0] r_man_l, r_man_s;

    assign w_exp_a_raw = a[OP_W-2 -: EXP_W];
    assign w_exp_b_raw = b[OP_W-2 -: EXP_W];

    // Denormals (exp field 0) behave as exponent 1 with a cleared hidden bit.
    assign w_exp_a = (|w_exp_a_raw) ? w_exp_a_raw : C_EXP_ONE;
    assign w_exp_b = (|w_exp_b_raw) ? w_exp_b_raw : C_EXP_ONE;
    assign w_sig_a = {|w_exp_a_raw, a[MAN_W-1:0]};
    assign w_sig_b = {|w_exp_b_raw, b[MAN_W-1:0]};

    // Ties go to A, so B is only chosen when strictly larger in magnitude.
    assign w_swap   = {w_exp_b, w_sig_b} > {w_exp_a, w_sig_a};
    assign w_exp_l  = w_swap ? w_exp_b : w_exp_a;
    assign w_exp_s  = w_swap ? w_exp_a : w_exp_b;
    assign w_sig_l  = w_swap ? w_sig_b : w_sig_a;
    assign w_sig_s  = w_swap ? w_sig_a : w_sig_b;
    assign w_sign_l = w_swap ? b[OP_W-1] : a[OP_W-1];
    assign w_sign_s = w_swap ? a[OP_W-1] : b[OP_W-1];

    assign w_diff     = w_exp_l - w_exp_s;
    assign w_cnt_init = (32'(w_diff) >= 32'(SIG_W)) ? C_CNT_MAX : CNT_W'(w_diff);
    assign w_special  = (&w_exp_a_raw) | (&w_exp_b_raw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (w_special || (w_cnt_init == '0)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (r_cnt == C_CNT_ONE) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_exp     <= '0;
            r_sign_l  <= 1'b0;
            r_sign_s  <= 1'b0;
            r_sub     <= 1'b0;
            r_swap    <= 1'b0;
            r_special <= 1'b0;
            r_man_l   <= '0;
            r_man_s   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cnt     <= w_cnt_init;
                        r_exp     <= w_exp_l;
                        r_sign_l  <= w_sign_l;
                        r_sign_s  <= w_sign_s;
                        r_sub     <= w_sign_l ^ w_sign_s;
                        r_swap    <= w_swap;
                        r_special <= w_special;
                        r_man_l   <= {w_sig_l, 3'b000};
                        r_man_s   <= {w_sig_s, 3'b000};
                    end
                end
                S_SHIFT: begin
                    // Bit 0 accumulates everything shifted past the round bit.
                    r_man_s <= {1'b0, r_man_s[SIG_W-1:2], r_man_s[1] | r_man_s[0]};
                    r_cnt   <= r_cnt - C_CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign out_exp     = r_exp;
    assign out_sign_l  = r_sign_l;
    assign out_sign_s  = r_sign_s;
    assign out_man_l   = r_man_l;
    assign out_man_s   = r_man_s;
    assign out_sub     = r_sub;
    assign out_swap    = r_swap;
    assign out_special = r_special;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_add_align
// Purpose  : Self-checking bench for fp_add_align against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_add_align;

    typedef struct packed {
        logic [7:0]  exp;
        logic        sl;
        logic        ss;
        logic        sub;
        logic        swap;
        logic        special;
        logic [26:0] ml;
        logic [26:0] ms;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_exp;
    logic        out_sign_l, out_sign_s;
    logic [26:0] out_man_l, out_man_s;
    logic        out_sub, out_swap, out_special;

    int tests = 0;
    int fails = 0;

    fp_add_align dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_exp    (out_exp),
        .out_sign_l (out_sign_l),
        .out_sign_s (out_sign_s),
        .out_man_l  (out_man_l),
        .out_man_s  (out_man_s),
        .out_sub    (out_sub),
        .out_swap   (out_swap),
        .out_special(out_special)
    );

    always #5 clk = ~clk;

    function automatic res_t observed();
        return {out_exp, out_sign_l, out_sign_s, out_sub, out_swap, out_special, out_man_l, out_man_s};
    endfunction

    // Value-level model: compare magnitudes as integers, align with a shift and
    // an OR-reduction of the discarded bits.
    function automatic res_t model(input logic [31:0] xa, input logic [31:0] xb, output int lat);
        longint ea, eb, sa, sb, el, es, sig_l, sig_s, d, n, sh;
        bit     swap, special;
        res_t   r;
        ea = (xa[30:23] == 8'd0) ? 64'd1 : longint'(xa[30:23]);
        eb = (xb[30:23] == 8'd0) ? 64'd1 : longint'(xb[30:23]);
        sa = longint'(xa[22:0]) + ((xa[30:23] == 8'd0) ? 0 : 2**23);
        sb = longint'(xb[22:0]) + ((xb[30:23] == 8'd0) ? 0 : 2**23);
        swap    = (eb * 2**24 + sb) > (ea * 2**24 + sa);
        el      = swap ? eb : ea;
        es      = swap ? ea : eb;
        sig_l   = swap ? sb : sa;
        sig_s   = swap ? sa : sb;
        special = (xa[30:23] == 8'hFF) || (xb[30:23] == 8'hFF);
        d       = el - es;
        n       = special ? 0 : ((d > 27) ? 27 : d);
        sh      = sig_s * 8;
        r.ms      = 27'((sh >> n) | (((sh & ((64'sd1 <<< n) - 1)) != 0) ? 1 : 0));
        r.ml      = 27'(sig_l * 8);
        r.exp     = 8'(el);
        r.sl      = swap ? xb[31] : xa[31];
        r.ss      = swap ? xa[31] : xb[31];
        r.sub     = r.sl != r.ss;
        r.swap    = swap;
        r.special = special;
        lat = 1 + int'(n);
        return r;
    endfunction

    task automatic send(input logic [31:0] xa, input logic [31:0] xb, output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1; a = xa; b = xb;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({out_valid, in_ready} !== 2'b01 || observed() !== '0) begin
            fails++;
            $display("FAIL reset_state: valid/ready=%b outs=%h, required 01 and 0", {out_valid, in_ready}, observed());
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [5] = '{32'h3F800000, 32'h3F800000, 32'h4B800000, 32'h7F000000, 32'h7F800000};
        logic [31:0] vb [5] = '{32'h3F800000, 32'h40000000, 32'h3F800001, 32'hBF800000, 32'h3F800000};
        logic [26:0] vms[5] = '{27'h4000000, 27'h2000000, 27'h0000005, 27'h0000001, 27'h4000000};
        int          vlat[5] = '{1, 2, 25, 28, 1};
        for (int i = 0; i < 5; i++) begin
            int   lat, mlat;
            res_t exp_r;
            exp_r = model(va[i], vb[i], mlat);
            send(va[i], vb[i], lat);
            tests++;
            if (lat !== vlat[i] || out_man_s !== vms[i]) begin
                fails++;
                $display("FAIL directed%0d_lat_man_s: lat=%0d man_s=%h, required lat=%0d man_s=%h",
                         i, lat, out_man_s, vlat[i], vms[i]);
            end
            tests++;
            if (observed() !== exp_r) begin
                fails++;
                $display("FAIL directed%0d_fields: got %h, required %h", i, observed(), exp_r);
            end
            release_result();
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL directed%0d_handoff: out_valid=%b in_ready=%b, required 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra, rb;
            int          lat, mlat;
            res_t        exp_r;
            ra = $urandom; rb = $urandom;
            case (i % 4)
                0: rb[30:23] = ra[30:23] + 8'($urandom_range(0, 3));
                1: rb[30:23] = 8'd0;
                2: rb[30:0]  = ra[30:0];
                default: ;
            endcase
            exp_r = model(ra, rb, mlat);
            send(ra, rb, lat);
            tests++;
            if (lat !== mlat || observed() !== exp_r) begin
                fails++;
                $display("FAIL random%0d a=%h b=%h: lat=%0d got %h, required lat=%0d %h",
                         i, ra, rb, lat, observed(), mlat, exp_r);
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int   lat, mlat;
        res_t exp_r;
        exp_r = model(32'h3F800000, 32'h40000000, mlat);
        send(32'h3F800000, 32'h40000000, lat);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0]; a = 32'h7F800000; b = $urandom;
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== exp_r) begin
                fails++;
                $display("FAIL backpressure%0d: valid=%b ready=%b outs=%h, required 1 0 %h",
                         k, out_valid, in_ready, observed(), exp_r);
            end
        end
        in_valid = 1'b0;
        release_result();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        int seen = 0;
        int lat, mlat;
        res_t exp_r;
        in_valid = 1'b1; a = 32'h4B800000; b = 32'h3F800001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || observed() !== '0) begin
            fails++;
            $display("FAIL reset_mid_shift: valid=%b ready=%b outs=%h, required 0 1 0", out_valid, in_ready, observed());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL reset_no_result: out_valid cycles=%0d, required 0", seen);
        end
        exp_r = model(32'h40000000, 32'h3F800000, mlat);
        send(32'h40000000, 32'h3F800000, lat);
        tests++;
        if (lat !== mlat || observed() !== exp_r) begin
            fails++;
            $display("FAIL reset_recovery: lat=%0d got %h, required lat=%0d %h", lat, observed(), mlat, exp_r);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_add_align.md
Name: fp_add_align

Overview:
- Pre-add alignment stage of the single-precision floating-point adder. Sits directly upstream of the mantissa adder datapath.
- Accepts two IEEE-754 binary32 operands over a valid/ready handshake and orders them by magnitude.
- Right-shifts the smaller significand one bit per cycle until both exponents match, keeping guard/round/sticky bits.
- Presents the aligned significands, common exponent and sign/operation info to the downstream adder over a second valid/ready handshake.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width.
- SIG_W, MAN_W+4, extended significand width: hidden bit, fraction, guard, round, sticky.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair a/b valid.
- in_ready  output  1  block can accept a pair.
- a  input  EXP_W+MAN_W+1  operand A, binary32.
- b  input  EXP_W+MAN_W+1  operand B, binary32.
- out_valid  output  1  aligned result valid.
- out_ready  input  1  downstream accepts result.
- out_exp  output  EXP_W  common (larger) effective exponent.
- out_sign_l  output  1  sign of larger-magnitude operand.
- out_sign_s  output  1  sign of smaller-magnitude operand.
- out_man_l  output  SIG_W  larger significand, unshifted: {hidden, frac, 3'b000}.
- out_man_s  output  SIG_W  smaller significand after alignment; bit 0 is sticky.
- out_sub  output  1  effective subtract (out_sign_l != out_sign_s).
- out_swap  output  1  B chosen as larger operand.
- out_special  output  1  either operand has exponent all-ones (Inf/NaN); no shift performed.

Behaviour:
- Reset is asynchronous on rst_n low:
  - state=IDLE.
  - All registered outputs zero: out_valid=0, out_exp=0, out_man_l=0, out_man_s=0, out_sign_l=0, out_sign_s=0, out_sub=0, out_swap=0, out_special=0.
  - in_ready=1 whenever state=IDLE, including immediately after reset.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid, capture the operands.
  - Effective exponent: exp==0 gives 1 with hidden bit 0 (denormal); otherwise the exponent with hidden bit 1.
  - Larger operand: larger effective exponent. If exponents are equal, larger {hidden, frac}. If fully equal, A is larger (out_swap=0).
  - Compute d = exp_l - exp_s as unsigned EXP_W-bit subtraction.
  - Load a shift counter with min(d, SIG_W).
  - Next state is DONE if the count is 0 or out_special=1. Otherwise next state is SHIFT.
- SHIFT:
  - Each cycle, man_s <= {0, man_s[SIG_W-1:2], man_s[1]|man_s[0]}, i.e. a logical right shift by 1 with the shifted-out bit ORed into sticky (bit 0).
  - Counter decrements each cycle; go to DONE when it reaches 1.
  - in_ready=0, out_valid=0.
- DONE:
  - out_valid=1 and all out_* held stable until out_ready=1.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
  - No new pair is accepted in the same cycle (in_ready=0 in DONE).
- Latency from the accept edge to out_valid high: 1 + min(d, SIG_W) cycles. d >= SIG_W saturates to SIG_W shifts, leaving out_man_s = sticky only.
- in_valid outside IDLE is ignored; operands are not sampled.
- a/b need not be held after the accept cycle.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation immediately. No partial result is ever emitted.
- Throughput: one result per (latency + 1) cycles minimum.

Test Plan:
1. a=0x3F800000 (1.0), b=0x3F800000, out_ready=1 -> out_valid 1 cycle after accept. out_exp=0x7F, out_man_l=out_man_s=0x4000000, out_swap=0, out_sub=0.
2. a=0x3F800000, b=0x40000000 (2.0) -> out_swap=1, out_exp=0x80, out_man_l=0x4000000, out_man_s=0x2000000. Latency 2.
3. a=0x4B800000 (2^24), b=0x3F800001, d=24 -> out_man_s=0x0000005 (sticky set by the shifted-out LSB). Latency 25.
4. a=0x7F000000, b=0xBF800000 (-1.0), d=127 -> 27 shifts, out_man_s=0x0000001, out_sub=1, out_sign_l=0. Latency 28.
5. a=0x7F800000 (Inf), b=0x3F800000 -> out_special=1, no shift, latency 1.
6. Backpressure and reset:
   - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, pulsed in_valid ignored.
   - Assert rst_n=0 mid-SHIFT in scenario 3 -> out_valid=0 and outputs zero immediately. in_ready=1 after release, no result emitted.
